// File: rtl/imem_program_loader.sv
// Instruction-memory writer: clears the RAM to NOP, loads a program from a valid/ready
// stream, then releases the core and serves its one-cycle-latency fetch reads.
module imem_program_loader #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              trunc
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W:0]   r_load_count;
    logic              r_trunc;
    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_fetch_data;
    logic [DATA_W-1:0] r_ram [DEPTH];

    logic              w_in_clear;
    logic              w_in_load;
    logic              w_in_run;
    logic              w_xfer;
    logic              w_fetch;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_in_clear  = (r_state == ST_CLEAR);
    assign w_in_load   = (r_state == ST_LOAD);
    assign w_in_run    = (r_state == ST_RUN);
    assign w_xfer      = w_in_load & ld_valid;
    // A reload in the same cycle as a fetch request suppresses the fetch.
    assign w_fetch     = w_in_run & fetch_en & ~reload;
    assign w_load_addr = r_load_count[ADDR_W-1:0];

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_clr_ptr;
        w_wr_data = NOP_WORD;
        if (!rst) begin
            if (w_in_clear) begin
                w_wr_en = 1'b1;
            end else if (w_xfer) begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_load_addr;
                w_wr_data = ld_data;
            end
        end
    end

    // NOTE: the RAM array has no reset; the CLEAR sweep initialises it, keeping it block-RAM inferable.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ram[w_wr_addr] <= w_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_clr_ptr    <= '0;
            r_load_count <= '0;
            r_trunc      <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_ADDR) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (!r_load_count[ADDR_W]) begin
                            r_load_count <= r_load_count + 1'b1;
                        end
                        // ld_last wins over the full-RAM condition, so a complete program never flags trunc.
                        if (ld_last) begin
                            r_state <= ST_RUN;
                        end else if (w_load_addr == LAST_ADDR) begin
                            r_trunc <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        r_state      <= ST_CLEAR;
                        r_clr_ptr    <= '0;
                        r_load_count <= '0;
                        r_trunc      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // fetch_data holds between RUN fetches, but reads as zero whenever the core is not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
        end else if (w_fetch) begin
            r_fetch_valid <= 1'b1;
            r_fetch_data  <= r_ram[fetch_addr];
        end else if (w_in_run && !reload) begin
            r_fetch_valid <= 1'b0;
        end else begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
        end
    end

    assign ld_ready    = w_in_load;
    assign cpu_run     = w_in_run;
    assign load_count  = r_load_count;
    assign trunc       = r_trunc;
    assign fetch_valid = r_fetch_valid;
    assign fetch_data  = r_fetch_data;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: a reference copy of the RAM feeds a fetch scoreboard
// that a negedge monitor drains whenever fetch_valid is seen.
module tb_imem_program_loader;

    localparam int          ADDR_W = 8;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] NOP    = 32'hF000_0000;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic              clk;
    logic              rst;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              reload;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
    logic              trunc;

    imem_program_loader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .reload     (reload),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .cpu_run    (cpu_run),
        .load_count (load_count),
        .trunc      (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          valid_cnt = 0;
    int          load_idx = 0;
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] sb_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("fetch_unexpected", 64'(fetch_valid), 64'd0);
            end else begin
                check("fetch_data", 64'(fetch_data), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = NOP;
        load_idx = 0;
    endtask

    // Counts negedges until ld_ready rises; cpu_run must stay low meanwhile.
    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        int bad_run = 0;
        while (ld_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (ld_ready !== 1'b1 && cpu_run !== 1'b0) bad_run++;
        end
        check(tag, 64'(n), 64'(exp_cycles));
        check({tag, "_cpu_run_low"}, 64'(bad_run), 64'd0);
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        check("ld_ready", 64'(ld_ready), 64'd1);
        exp_mem[load_idx] = w;
        load_idx++;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = JUNK;
    endtask

    // Issues n back-to-back fetches; every one must be answered exactly one cycle later.
    task automatic fetch_seq(input int first, input int n);
        #1;
        valid_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            fetch_en   = 1'b1;
            fetch_addr = 8'(first + i);
            sb_q.push_back(exp_mem[8'(first + i)]);
            @(negedge clk);
        end
        fetch_en = 1'b0;
        #1;
        check("fetch_drain", 64'(sb_q.size()), 64'd0);
        check("fetch_valid_count", 64'(valid_cnt), 64'(n));
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        wait_ready("reload_clear_cycles", DEPTH);
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] prog [6];

    initial begin
        prog[0] = 32'h1000_0005;
        prog[1] = 32'h1100_0003;
        prog[2] = 32'h2201_0000;
        prog[3] = 32'h3302_0000;
        prog[4] = 32'h4023_0000;
        prog[5] = 32'h5223_0000;

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_ld_ready",    64'(ld_ready),    64'd0);
        check("rst_cpu_run",     64'(cpu_run),     64'd0);
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_fetch_data",  64'(fetch_data),  64'd0);
        check("rst_load_count",  64'(load_count),  64'd0);
        check("rst_trunc",       64'(trunc),       64'd0);

        // Reset release: CLEAR takes exactly DEPTH cycles.
        rst = 1'b0;
        clear_model();
        wait_ready("clear_cycles", DEPTH);

        // Six-word program with ld_last on the sixth.
        for (int i = 0; i < 6; i++) load_word(prog[i], i == 5);
        check("prog_cpu_run",    64'(cpu_run),    64'd1);
        check("prog_load_count", 64'(load_count), 64'd6);
        check("prog_ld_ready",   64'(ld_ready),   64'd0);
        check("prog_trunc",      64'(trunc),      64'd0);
        // Words offered while running must be ignored.
        ld_valid = 1'b1; ld_data = JUNK; ld_last = 1'b1;
        repeat (3) @(negedge clk);
        check("run_ld_ready", 64'(ld_ready), 64'd0);
        ld_valid = 1'b0; ld_last = 1'b0;
        fetch_seq(0, 7);
        fetch_seq(0, 3);
        fetch_seq(255, 1);
        check("run_load_count_stable", 64'(load_count), 64'd6);

        // Reload together with a fetch request; ld_valid and fetch_en held through CLEAR.
        reload = 1'b1; fetch_en = 1'b1; fetch_addr = 8'd1;
        ld_valid = 1'b1; ld_data = JUNK;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_run",     64'(cpu_run),     64'd0);
        check("reload_fetch_valid", 64'(fetch_valid), 64'd0);
        check("reload_fetch_data",  64'(fetch_data),  64'd0);
        check("reload_load_count",  64'(load_count),  64'd0);
        check("reload_ld_ready",    64'(ld_ready),    64'd0);
        wait_ready("reload_clear_cycles", DEPTH);
        ld_valid = 1'b0; fetch_en = 1'b0;
        clear_model();
        load_word(32'h6000_0011, 1'b0);
        load_word(32'h6100_0022, 1'b1);
        check("reload2_load_count", 64'(load_count), 64'd2);
        check("reload2_cpu_run",    64'(cpu_run),    64'd1);
        fetch_seq(0, 3);

        // Throttled load: idle cycles carry junk data with ld_valid low.
        do_reload();
        for (int i = 0; i < 8; i++) begin
            load_word(32'h7000_0100 + 32'(i), i == 7);
            if (i < 7) begin
                ld_data = 32'hBAD0_0000 + 32'(i);
                @(negedge clk);
            end
        end
        check("thr_load_count", 64'(load_count), 64'd8);
        check("thr_cpu_run",    64'(cpu_run),    64'd1);
        fetch_seq(0, 9);

        // Full RAM with no ld_last: truncation.
        do_reload();
        check("trunc_cleared", 64'(trunc), 64'd0);
        for (int i = 0; i < DEPTH; i++) load_word(32'hA500_0000 | 32'(i), 1'b0);
        check("trunc_flag",       64'(trunc),      64'd1);
        check("trunc_cpu_run",    64'(cpu_run),    64'd1);
        check("trunc_load_count", 64'(load_count), 64'd256);
        check("trunc_ld_ready",   64'(ld_ready),   64'd0);
        fetch_seq(254, 2);
        fetch_seq(0, 1);

        // Full RAM with ld_last on the final word: no truncation.
        do_reload();
        check("last_trunc_cleared", 64'(trunc), 64'd0);
        for (int i = 0; i < DEPTH; i++) load_word(32'hC300_0000 | 32'(i), i == DEPTH - 1);
        check("last_trunc",      64'(trunc),      64'd0);
        check("last_cpu_run",    64'(cpu_run),    64'd1);
        check("last_load_count", 64'(load_count), 64'd256);
        fetch_seq(255, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
